// File: rtl/store_checker_pkg.sv
// Shared types for the MIPS store-bus checker: verdict states, fail codes and log entries.
`timescale 1ns/1ps
package store_check_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_BAD_ADDR = 2'd1,
    FC_BAD_DATA = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fail_code_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  localparam logic [15:0] STORE_COUNT_MAX = 16'hFFFF;

  // Saturating increment for the 16-bit store counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STORE_COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/store_log_fifo.sv
// First-word fall-through FIFO logging captured stores, with sticky drop-on-full flag.
`timescale 1ns/1ps
module store_log_fifo
  import store_check_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  log_entry_t i_entry,
  input  logic       i_pop,
  output logic       o_valid,
  output log_entry_t o_head,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);

  log_entry_t       r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (i_push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_entry;
  end

  assign o_valid    = !w_empty;
  assign o_head     = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/store_checker.sv
// End-of-program checker on the MIPS data-memory store bus: verdict FSM, timeout, store counter, store log.
`timescale 1ns/1ps
module store_checker
  import store_check_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd8,
  parameter logic [31:0] ALLOW_ADDR     = 32'd80,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          DEPTH          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  input  logic        log_rd_en,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  fail_code_t       r_fail_code;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_store_count;

  logic             w_run;
  logic             w_store;
  logic             w_term;
  logic             w_timeout;
  state_t           w_next_state;
  fail_code_t       w_next_code;
  log_entry_t       w_entry;
  log_entry_t       w_head;

  assign w_run     = (r_state == RUN);
  assign w_store   = w_run && memwrite;
  // Any store not to the allowed scratch address ends the run.
  assign w_term    = w_store && ((dataadr == PASS_ADDR) || (dataadr != ALLOW_ADDR));
  assign w_timeout = w_run && (r_cnt == CNT_LAST);

  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_fail_code;
    if (w_term) begin
      if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
        w_next_state = PASS;
      end else if (dataadr == PASS_ADDR) begin
        w_next_state = FAIL;
        w_next_code  = FC_BAD_DATA;
      end else begin
        w_next_state = FAIL;
        w_next_code  = FC_BAD_ADDR;
      end
    end else if (w_timeout) begin
      w_next_state = FAIL;
      w_next_code  = FC_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_fail_code   <= FC_NONE;
      r_cnt         <= '0;
      r_store_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_fail_code <= w_next_code;
      if (w_run && !w_timeout) r_cnt <= r_cnt + CNT_W'(1);
      if (w_store) r_store_count <= sat_inc16(r_store_count);
    end
  end

  assign w_entry = '{addr: dataadr, data: writedata};

  store_log_fifo #(
    .DEPTH(DEPTH)
  ) u_log (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_store),
    .i_entry    (w_entry),
    .i_pop      (log_rd_en),
    .o_valid    (log_valid),
    .o_head     (w_head),
    .o_overflow (log_overflow)
  );

  assign done        = (r_state != RUN);
  assign pass        = (r_state == PASS);
  assign fail_code   = r_fail_code;
  assign store_count = r_store_count;
  assign log_addr    = w_head.addr;
  assign log_data    = w_head.data;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: queue-based reference model checked every cycle plus literal checkpoints.
`timescale 1ns/1ps
module tb_store_checker;

  localparam logic [31:0] P_ADDR = 32'd84;
  localparam logic [31:0] P_DATA = 32'd8;
  localparam logic [31:0] A_ADDR = 32'd80;
  localparam int          T_OUT  = 50;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        log_rd_en = 1'b0;
  logic        done, pass, log_valid, log_overflow;
  logic [1:0]  fail_code;
  logic [15:0] store_count;
  logic [31:0] log_addr, log_data;

  int n_checks = 0;
  int n_err = 0;

  store_checker #(
    .PASS_ADDR(P_ADDR), .PASS_DATA(P_DATA), .ALLOW_ADDR(A_ADDR),
    .TIMEOUT_CYCLES(T_OUT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail_code(fail_code),
    .store_count(store_count), .log_rd_en(log_rd_en), .log_valid(log_valid),
    .log_addr(log_addr), .log_data(log_data), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: verdict flags, store tally, edge count and a queue for the log.
  logic          m_done, m_pass, m_ovf;
  logic [1:0]    m_code;
  int            m_count, m_edges;
  logic [63:0]   m_log[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_done = 0; m_pass = 0; m_ovf = 0; m_code = 0;
      m_count = 0; m_edges = 0; m_log.delete();
    end else begin
      if (log_rd_en && m_log.size() > 0) void'(m_log.pop_front());
      if (!m_done) begin
        m_edges++;
        if (memwrite) begin
          if (m_count < 65535) m_count++;
          if (m_log.size() < DEPTH) m_log.push_back({dataadr, writedata});
          else m_ovf = 1;
        end
        if (memwrite && dataadr == P_ADDR) begin
          m_done = 1;
          if (writedata == P_DATA) m_pass = 1;
          else m_code = 2;
        end else if (memwrite && dataadr != A_ADDR) begin
          m_done = 1; m_code = 1;
        end else if (m_edges == T_OUT) begin
          m_done = 1; m_code = 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("done", done, m_done);
      chk("pass", pass, m_pass);
      chk("fail_code", fail_code, m_code);
      chk("store_count", store_count, m_count[15:0]);
      chk("log_valid", log_valid, m_log.size() > 0);
      chk("log_overflow", log_overflow, m_ovf);
      if (m_log.size() > 0) chk("log_head", {log_addr, log_data}, m_log[0]);
    end
  end

  task automatic do_reset();
    reset = 0; memwrite = 0; log_rd_en = 0; dataadr = '0; writedata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    @(posedge clk); #1;
    memwrite = 0;
  endtask

  task automatic pop_expect(input string name, input logic [31:0] a, input logic [31:0] d);
    chk({name, "_valid"}, log_valid, 1'b1);
    chk({name, "_addr"}, log_addr, a);
    chk({name, "_data"}, log_data, d);
    log_rd_en = 1;
    @(posedge clk); #1;
    log_rd_en = 0;
  endtask

  initial begin
    #1;
    chk("rst_done", done, 0);
    chk("rst_count", store_count, 0);
    chk("rst_valid", log_valid, 0);
    chk("rst_ovf", log_overflow, 0);

    // Allowed store then pass store.
    do_reset();
    store(80, 7);
    chk("t1_mid_done", done, 0);
    store(84, 8);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_code", fail_code, 0);
    chk("t1_count", store_count, 2);
    pop_expect("t1_pop0", 80, 7);
    pop_expect("t1_pop1", 84, 8);
    chk("t1_empty", log_valid, 0);

    // Bad address, later stores ignored.
    do_reset();
    store(88, 5);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_code", fail_code, 1);
    store(84, 8);
    chk("t2_count", store_count, 1);
    chk("t2_pass_after", pass, 0);

    // Wrong pass data.
    do_reset();
    store(84, 9);
    chk("t3_code", fail_code, 2);
    chk("t3_pass", pass, 0);

    // Timeout with no stores.
    do_reset();
    repeat (T_OUT - 1) @(posedge clk);
    #1 chk("t4_done_early", done, 0);
    @(posedge clk); #1;
    chk("t4_done", done, 1);
    chk("t4_code", fail_code, 3);

    // Pass store on the very timeout edge wins.
    do_reset();
    repeat (T_OUT - 1) @(posedge clk);
    #1 store(84, 8);
    chk("t5_pass", pass, 1);
    chk("t5_code", fail_code, 0);

    // Overflow: ten stores into an eight-entry log.
    do_reset();
    for (int i = 0; i < 10; i++) store(80, i);
    chk("t6_ovf", log_overflow, 1);
    chk("t6_count", store_count, 10);
    for (int i = 0; i < DEPTH; i++) pop_expect("t6_pop", 80, i);
    chk("t6_empty", log_valid, 0);

    // Full log, push and pop on the same edge.
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(80, i);
    chk("t7_ovf_full", log_overflow, 0);
    log_rd_en = 1;
    store(80, 99);
    log_rd_en = 0;
    chk("t7_ovf_after", log_overflow, 0);
    for (int i = 1; i < DEPTH; i++) pop_expect("t7_pop", 80, i);
    pop_expect("t7_pop_new", 80, 99);
    chk("t7_empty", log_valid, 0);

    // Asynchronous reset mid-run, then a fresh passing run.
    do_reset();
    for (int i = 0; i < 3; i++) store(80, i);
    #2 reset = 0;
    #1;
    chk("t8_done", done, 0);
    chk("t8_pass", pass, 0);
    chk("t8_code", fail_code, 0);
    chk("t8_count", store_count, 0);
    chk("t8_valid", log_valid, 0);
    chk("t8_addr", log_addr, 0);
    chk("t8_data", log_data, 0);
    chk("t8_ovf", log_overflow, 0);
    @(posedge clk); #1 reset = 1;
    store(84, 8);
    chk("t8_pass_again", pass, 1);
    chk("t8_count_again", store_count, 1);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
